uart_reg_responder: RTL and testbench

- Byte-level command responder that sits between a uart_rx (host->device) and a uart_tx (device->host). It is the device end of a host register-access link.
- Parses single-byte-opcode commands from the received byte stream and maintains a small 8-bit register file.
- Emits exactly one response byte per completed or rejected command, through the transmitter's send strobe.

---
 rtl/uart_reg_responder.sv | 163 ++++++++++++++++
 tb/tb_uart_reg_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_responder.sv
// Byte-level register-access responder between a uart_rx and a uart_tx.
// Define UART_REG_CKSUM_EN to require a trailing XOR checksum byte on every R/W command.
module uart_reg_responder #(
  parameter int NREGS   = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic [7:0]           out_data,
  output logic                 out_send,
  input  logic                 tx_busy,
  output logic [8*NREGS-1:0]   regs_flat,
  output logic                 wr_stb,
  output logic                 err_drop
);

  localparam logic [7:0] OP_R     = 8'h52;
  localparam logic [7:0] OP_W     = 8'h57;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_BAD  = 8'h3F;
  localparam int         CW       = $clog2(TIMEOUT + 1);

`ifdef UART_REG_CKSUM_EN
  localparam logic [7:0] RSP_CKS  = 8'h21;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CKSUM, S_RESP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
`endif

  state_t        state, next_state;
  logic [7:0]    opcode_q, addr_q, data_q;
  logic [CW-1:0] tcnt_q;
  logic          counting, tmo_hit, decide, cks_bad, addr_ok, do_write, enter_resp;
  logic [7:0]    cur_addr, cur_data, reply;
`ifdef UART_REG_CKSUM_EN
  logic [7:0]    cks_q;
  assign counting = (state == S_ADDR) || (state == S_DATA) || (state == S_CKSUM);
`else
  assign counting = (state == S_ADDR) || (state == S_DATA);
`endif

  // The byte wins over an expiring timeout: tmo_hit is only consulted when in_valid is low.
  assign tmo_hit    = counting && (tcnt_q == CW'(TIMEOUT - 1));
  assign addr_ok    = 32'(cur_addr) < 32'(NREGS);
  assign enter_resp = (next_state == S_RESP) && (state != S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    decide     = 1'b0;
    cks_bad    = 1'b0;
    cur_addr   = addr_q;
    cur_data   = data_q;
    unique case (state)
      S_IDLE: if (in_valid) next_state = (in_data == OP_R || in_data == OP_W) ? S_ADDR : S_RESP;
      S_ADDR: begin
        if (in_valid) begin
          cur_addr = in_data;
`ifdef UART_REG_CKSUM_EN
          next_state = (opcode_q == OP_W) ? S_DATA : S_CKSUM;
`else
          if (opcode_q == OP_W) next_state = S_DATA;
          else begin
            next_state = S_RESP;
            decide     = 1'b1;
          end
`endif
        end else if (tmo_hit) next_state = S_IDLE;
      end
      S_DATA: begin
        if (in_valid) begin
          cur_data = in_data;
`ifdef UART_REG_CKSUM_EN
          next_state = S_CKSUM;
`else
          next_state = S_RESP;
          decide     = 1'b1;
`endif
        end else if (tmo_hit) next_state = S_IDLE;
      end
`ifdef UART_REG_CKSUM_EN
      S_CKSUM: begin
        if (in_valid) begin
          next_state = S_RESP;
          decide     = 1'b1;
          cks_bad    = (in_data != cks_q);
        end else if (tmo_hit) next_state = S_IDLE;
      end
`endif
      S_RESP:  if (!tx_busy) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase

    // Reply for the command completing this cycle; unknown opcodes keep the '?' default.
    reply    = RSP_BAD;
    do_write = 1'b0;
    if (decide) begin
`ifdef UART_REG_CKSUM_EN
      if (cks_bad) reply = RSP_CKS;
      else
`endif
      if (addr_ok) begin
        if (opcode_q == OP_W) begin
          reply    = RSP_OK;
          do_write = 1'b1;
        end else begin
          reply = regs_flat[8*cur_addr +: 8];
        end
      end
    end
  end

  always_comb begin
    out_send = (state == S_RESP) && !tx_busy;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      tcnt_q    <= '0;
      out_data  <= '0;
      wr_stb    <= 1'b0;
      err_drop  <= 1'b0;
      // NOTE: the register file is cleared on reset because hosts rely on reading 0x00 after reset.
      regs_flat <= '0;
`ifdef UART_REG_CKSUM_EN
      cks_q     <= '0;
`endif
    end else begin
      wr_stb <= do_write;
      if (in_valid || !counting) tcnt_q <= '0;
      else                       tcnt_q <= tcnt_q + 1'b1;

      if (in_valid) begin
        unique case (state)
          S_IDLE: opcode_q <= in_data;
          S_ADDR: addr_q   <= in_data;
          S_DATA: data_q   <= in_data;
          S_RESP: err_drop <= 1'b1;
          default: ;
        endcase
`ifdef UART_REG_CKSUM_EN
        if (state == S_IDLE) cks_q <= in_data;
        else                 cks_q <= cks_q ^ in_data;
`endif
      end

      if (enter_resp) out_data <= reply;
      if (do_write)   regs_flat[8*cur_addr +: 8] <= cur_data;
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: expected replies are queued at stimulus time
// and a negedge monitor pops and compares them on every out_send.
module tb_uart_reg_responder;

  localparam int NREGS   = 16;
  localparam int TIMEOUT = 50;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [7:0]           in_data = '0;
  logic                 in_valid = 1'b0;
  logic [7:0]           out_data;
  logic                 out_send;
  logic                 tx_busy = 1'b0;
  logic [8*NREGS-1:0]   regs_flat;
  logic                 wr_stb;
  logic                 err_drop;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         n_sends = 0;
  int         n_wr = 0;
  int         send_cyc = -1;
  logic [7:0] exp_q[$];

  uart_reg_responder #(.NREGS(NREGS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_send(out_send), .tx_busy(tx_busy),
    .regs_flat(regs_flat), .wr_stb(wr_stb), .err_drop(err_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every transmitted byte against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && wr_stb) n_wr++;
    if (!rst && out_send) begin
      n_sends++;
      send_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_send: got byte %0h with no reply pending (cycle %0d)", out_data, cyc);
      end else begin
        check("reply", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one byte for exactly one cycle; returns #1 after the edge that sampled it.
  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends the last byte of a command after pushing its expected reply.
  task automatic send_last(input logic [7:0] b, input logic [7:0] exp);
    exp_q.push_back(exp);
    send_byte(b);
  endtask

  task automatic cmd_r(input logic [7:0] addr, input logic [7:0] exp);
    send_byte(8'h52);
`ifdef UART_REG_CKSUM_EN
    send_byte(addr);
    send_last(8'h52 ^ addr, exp);
`else
    send_last(addr, exp);
`endif
  endtask

  task automatic cmd_w(input logic [7:0] addr, input logic [7:0] data, input logic [7:0] exp);
    send_byte(8'h57);
    send_byte(addr);
`ifdef UART_REG_CKSUM_EN
    send_byte(data);
    send_last(8'h57 ^ addr ^ data, exp);
`else
    send_last(data, exp);
`endif
  endtask

  task automatic wait_resp(input string name);
    int budget = 100;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no reply within 100 cycles, %0d pending", name, exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  initial begin
    logic [8*NREGS-1:0] snap;
    int wr0, rel_cyc, sends0;

    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_send", out_send, 1'b0);
    check("rst_wr_stb", wr_stb, 1'b0);
    check("rst_err_drop", err_drop, 1'b0);
    check("rst_regs", regs_flat, '0);

    // Write then read back; data visible and wr_stb high one cycle after the final byte.
    cmd_w(8'h03, 8'hA5, 8'h4B);
    check("wr_reg3", regs_flat[31:24], 8'hA5);
    check("wr_stb_pulse", wr_stb, 1'b1);
    tick(1);
    check("wr_stb_drop", wr_stb, 1'b0);
    wait_resp("write3");
    cmd_r(8'h03, 8'hA5);
    wait_resp("read3");

    // Last valid address.
    cmd_w(8'h0F, 8'h5A, 8'h4B);
    wait_resp("write15");
    check("wr_reg15", regs_flat[127:120], 8'h5A);
    cmd_r(8'h0F, 8'h5A);
    wait_resp("read15");

    // Unknown opcode and out-of-range address.
    send_last(8'h00, 8'h3F);
    wait_resp("bad_op");
    snap = regs_flat;
    wr0  = n_wr;
    cmd_w(8'h10, 8'h55, 8'h3F);
    wait_resp("bad_addr_w");
    check("bad_addr_regs", regs_flat, snap);
    check("bad_addr_no_wr_stb", n_wr - wr0, 0);
    cmd_r(8'hFF, 8'h3F);
    wait_resp("bad_addr_r");

    // Busy transmitter: reply held back, extra byte dropped, one send when busy falls.
    tx_busy = 1'b1;
    sends0  = n_sends;
    cmd_w(8'h05, 8'h77, 8'h4B);
    tick(5);
    send_byte(8'h99);
    check("err_drop_set", err_drop, 1'b1);
    tick(13);
    check("no_send_while_busy", n_sends - sends0, 0);
    tx_busy = 1'b0;
    rel_cyc = cyc;
    wait_resp("busy");
    check("send_cycle", send_cyc, rel_cyc);
    check("busy_one_send", n_sends - sends0, 1);
    check("out_data_stable", out_data, 8'h4B);
    check("busy_reg5", regs_flat[47:40], 8'h77);

    // Timeout: a 60-cycle gap aborts the write, a 49-cycle gap does not.
    send_byte(8'h57);
    send_byte(8'h01);
    tick(60);
    cmd_r(8'h01, 8'h00);
    wait_resp("after_abort");
    check("abort_reg1", regs_flat[15:8], 8'h00);
    send_byte(8'h57);
    send_byte(8'h01);
    tick(49);
`ifdef UART_REG_CKSUM_EN
    send_byte(8'hC3);
    send_last(8'h57 ^ 8'h01 ^ 8'hC3, 8'h4B);
`else
    send_last(8'hC3, 8'h4B);
`endif
    wait_resp("gap49");
    check("gap49_reg1", regs_flat[15:8], 8'hC3);

    // Reset mid-command: the following byte is a fresh (unknown) opcode.
    send_byte(8'h57);
    send_byte(8'h02);
    rst = 1'b1;
    #2;
    check("midrst_regs", regs_flat, '0);
    check("midrst_out_data", out_data, 8'h00);
    check("midrst_err_drop", err_drop, 1'b0);
    check("midrst_wr_stb", wr_stb, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(1);
    send_last(8'h77, 8'h3F);
    wait_resp("after_rst");
    check("after_rst_reg2", regs_flat[23:16], 8'h00);

`ifdef UART_REG_CKSUM_EN
    // Raw checksum vectors: 0x57^0x01^0x3C = 0x6A.
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h3C);
    send_last(8'h6A, 8'h4B);
    wait_resp("cks_good");
    check("cks_good_reg1", regs_flat[15:8], 8'h3C);
    wr0 = n_wr;
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h99);
    send_last(8'h00, 8'h21);
    wait_resp("cks_bad");
    check("cks_bad_reg1", regs_flat[15:8], 8'h3C);
    check("cks_bad_no_wr_stb", n_wr - wr0, 0);
    // Mismatch outranks the out-of-range address.
    send_byte(8'h52); send_byte(8'h20);
    send_last(8'h00, 8'h21);
    wait_resp("cks_bad_range");
`endif

    tick(5);
    check("no_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

endmodule
